// File: rtl/ofdm_tx_sample_buffer.sv
// Elastic I/Q sample buffer between the OFDM frame generator and the DAC side.
// Primes to a fill level, streams on DAC strobes, zero-fills on underflow,
// and drains to empty after end of transmission.
module ofdm_tx_sample_buffer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned PRIME_LEVEL = 256,
  parameter int unsigned AF_MARGIN   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DATA_W-1:0] in_data_q,
  input  logic              in_done,
  output logic              o_wayt_read_data,
  input  logic              dac_strobe,
  output logic [DATA_W-1:0] out_data_i,
  output logic [DATA_W-1:0] out_data_q,
  output logic              out_valid,
  output logic              underflow,
  output logic [15:0]       underflow_cnt,
  output logic              overflow,
  output logic [ADDR_W:0]   level,
  output logic              o_done,
  output logic [1:0]        o_state
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [DATA_W-1:0]   r_out_i;
  logic [DATA_W-1:0]   r_out_q;
  logic                r_out_valid;
  logic                r_underflow;
  logic [15:0]         r_uf_cnt;
  logic                r_overflow;
  logic                r_done;
  logic                r_done_seen;
  logic                r_wayt;

  logic                w_full;
  logic                w_empty;
  logic                w_wr;
  logic                w_rd;
  logic                w_uf;
  logic                w_drain_done;
  logic                w_rd_state;
  logic                w_uf_state;
  logic                w_done_armed;
  logic [WORD_W-1:0]   w_rd_word;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_wr      = in_valid & ~w_full;
  assign w_rd      = dac_strobe & w_rd_state & ~w_empty;
  assign w_uf      = dac_strobe & w_uf_state & w_empty;
  assign w_rd_word = r_mem[r_rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Next-state logic; done_seen outranks reaching the prime level
  always_comb begin
    w_next       = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr) w_next = S_PRIME;
      end
      S_PRIME: begin
        if (r_done_seen) w_next = S_DRAIN;
        else if (r_level >= LVL_W'(PRIME_LEVEL)) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (r_done_seen) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty && !w_wr) begin
          w_next       = S_IDLE;
          w_drain_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded qualifiers for the datapath
  always_comb begin
    w_rd_state   = 1'b0;
    w_uf_state   = 1'b0;
    w_done_armed = 1'b0;
    case (r_state)
      S_PRIME:  w_done_armed = 1'b1;
      S_STREAM: begin
        w_rd_state   = 1'b1;
        w_uf_state   = 1'b1;
        w_done_armed = 1'b1;
      end
      S_DRAIN: begin
        w_rd_state   = 1'b1;
        w_done_armed = 1'b1;
      end
      default: ;
    endcase
  end

  // Sample storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (en && !reset && w_wr) begin
      r_mem[r_wr_ptr] <= {in_data_i, in_data_q};
    end
  end

  // Pointers, occupancy, output sample and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_uf_cnt    <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_done_seen <= 1'b0;
      r_wayt      <= 1'b1;
    end else if (!en) begin
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= w_rd | w_uf;
      r_underflow <= w_uf;
      r_done      <= w_drain_done;
      if (w_rd) begin
        r_out_i  <= w_rd_word[WORD_W-1:DATA_W];
        r_out_q  <= w_rd_word[DATA_W-1:0];
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end else if (w_uf) begin
        r_out_i <= '0;
        r_out_q <= '0;
      end
      if (w_uf && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
      if (in_valid && w_full) r_overflow <= 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      r_wayt <= (LVL_W'(DEPTH) - r_level) > LVL_W'(AF_MARGIN);
      if (w_drain_done) r_done_seen <= 1'b0;
      else if (in_done && w_done_armed) r_done_seen <= 1'b1;
    end
  end

  assign o_wayt_read_data = r_wayt;
  assign out_data_i       = r_out_i;
  assign out_data_q       = r_out_q;
  assign out_valid        = r_out_valid & en;
  assign underflow        = r_underflow & en;
  assign o_done           = r_done & en;
  assign underflow_cnt    = r_uf_cnt;
  assign overflow         = r_overflow;
  assign level            = r_level;
  assign o_state          = r_state;

endmodule

// File: tb/tb_ofdm_tx_sample_buffer.sv
// Self-checking bench for ofdm_tx_sample_buffer: directed phases plus a random
// soak, all compared against a queue-based reference model.
module tb_ofdm_tx_sample_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;
  localparam int PRIME  = 256;
  localparam int AFM    = 8;

  logic              clk = 1'b0;
  logic              reset, en, in_valid, in_done, dac_strobe;
  logic [DATA_W-1:0] in_data_i, in_data_q;
  logic              o_wayt_read_data, out_valid, underflow, overflow, o_done;
  logic [DATA_W-1:0] out_data_i, out_data_q;
  logic [15:0]       underflow_cnt;
  logic [ADDR_W:0]   level;
  logic [1:0]        o_state;

  always #5 clk = ~clk;

  ofdm_tx_sample_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .in_valid         (in_valid),
    .in_data_i        (in_data_i),
    .in_data_q        (in_data_q),
    .in_done          (in_done),
    .o_wayt_read_data (o_wayt_read_data),
    .dac_strobe       (dac_strobe),
    .out_data_i       (out_data_i),
    .out_data_q       (out_data_q),
    .out_valid        (out_valid),
    .underflow        (underflow),
    .underflow_cnt    (underflow_cnt),
    .overflow         (overflow),
    .level            (level),
    .o_done           (o_done),
    .o_state          (o_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents as a queue, behaviour from the block's rules
  logic [31:0] mq[$];
  int          m_state;
  bit          m_ds, m_ovf, m_valid, m_uf, m_done, m_wayt;
  int          m_cnt;
  logic [31:0] m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int lvl, st;
    bit wr, rd;
    if (reset) begin
      mq.delete();
      m_state = 0; m_ds = 0; m_cnt = 0; m_ovf = 0; m_out = '0;
      m_valid = 0; m_uf = 0; m_done = 0; m_wayt = 1;
      return;
    end
    if (!en) begin
      m_valid = 0; m_uf = 0; m_done = 0;
      return;
    end
    lvl = mq.size();
    st  = m_state;
    wr  = in_valid && lvl < DEPTH;
    rd  = dac_strobe && (st == 2 || st == 3) && lvl > 0;
    m_valid = 0; m_uf = 0; m_done = 0;
    if (rd) begin
      m_out = mq.pop_front();
      m_valid = 1;
    end else if (dac_strobe && st == 2) begin
      m_out = '0; m_valid = 1; m_uf = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (in_valid && !wr) m_ovf = 1;
    if (wr) mq.push_back({in_data_i, in_data_q});
    m_wayt = (DEPTH - lvl) > AFM;
    case (st)
      0: if (wr) m_state = 1;
      1: if (m_ds) m_state = 3; else if (lvl >= PRIME) m_state = 2;
      2: if (m_ds) m_state = 3;
      default: if (lvl == 0 && !wr) begin m_state = 0; m_done = 1; end
    endcase
    if (m_done) m_ds = 0;
    else if (in_done && st != 0) m_ds = 1;
  endtask

  task automatic check_all();
    chk("level",     32'(level),            32'(mq.size()));
    chk("state",     32'(o_state),          32'(m_state));
    chk("out_valid", 32'(out_valid),        32'(m_valid));
    chk("underflow", 32'(underflow),        32'(m_uf));
    chk("o_done",    32'(o_done),           32'(m_done));
    chk("overflow",  32'(overflow),         32'(m_ovf));
    chk("uf_cnt",    32'(underflow_cnt),    32'(m_cnt));
    chk("wayt",      32'(o_wayt_read_data), 32'(m_wayt));
    chk("out_i",     32'(out_data_i),       32'(m_out[31:16]));
    chk("out_q",     32'(out_data_q),       32'(m_out[15:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    reset = 0; en = 1; in_valid = 0; in_done = 0; dac_strobe = 0;
    in_data_i = '0; in_data_q = '0;
  endtask

  task automatic rand_data();
    in_data_i = 16'($urandom);
    in_data_q = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_k, uf_seen, outs, dones;
    bit got;
    logic [15:0] eq;

    // Reset with all inputs low
    quiet(); en = 0; reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_wayt",  32'(o_wayt_read_data), 32'd1);
    chk("rst_level", 32'(level),            32'd0);
    chk("rst_state", 32'(o_state),          32'd0);

    // Prime with a ramp while strobing every cycle; output must follow the ramp
    quiet();
    exp_k = 0;
    for (int k = 0; k < 256; k++) begin
      in_valid = 1; dac_strobe = 1;
      in_data_i = 16'(k); in_data_q = 16'(0 - k);
      tick();
      if (out_valid) begin
        chk("valid_before_stream", 32'(o_state), 32'd2);
        chk("ramp_i", 32'(out_data_i), 32'(exp_k));
        exp_k++;
      end
    end
    in_valid = 0;
    for (int n = 0; n < 400 && level != 0; n++) begin
      tick();
      if (out_valid) begin
        eq = 16'(0 - exp_k);
        chk("ramp_i", 32'(out_data_i), 32'(exp_k));
        chk("ramp_q", 32'(out_data_q), 32'(eq));
        exp_k++;
      end
    end
    chk("ramp_count", 32'(exp_k), 32'd256);

    // Underflow: four strobes on an empty buffer in STREAM
    uf_seen = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (underflow && out_valid && out_data_i == 0 && out_data_q == 0) uf_seen++;
    end
    dac_strobe = 0;
    tick();
    chk("uf_pulses", 32'(uf_seen),       32'd4);
    chk("uf_cnt4",   32'(underflow_cnt), 32'd4);
    chk("uf_state",  32'(o_state),       32'd2);

    // Reset mid-STREAM at level 50
    for (int n = 0; n < 50; n++) begin
      in_valid = 1; rand_data();
      tick();
    end
    quiet();
    chk("mid_level", 32'(level), 32'd50);
    reset = 1;
    tick();
    chk("mid_rst_level", 32'(level),   32'd0);
    chk("mid_rst_state", 32'(o_state), 32'd0);
    reset = 0;

    // Backpressure: write only while upstream is allowed
    got = 0;
    for (int n = 0; n < 2200; n++) begin
      if (!o_wayt_read_data) begin got = 1; break; end
      in_valid = 1; rand_data();
      tick();
    end
    chk("bp_flag_drop", 32'(got), 32'd1);
    chk("bp_level_hi",  32'(level >= 12'd2040), 32'd1);
    chk("bp_no_ovf",    32'(overflow), 32'd0);
    for (int n = 0; n < 12; n++) begin
      in_valid = 1; rand_data();
      tick();
    end
    chk("full_level", 32'(level),    32'd2048);
    chk("full_ovf",   32'(overflow), 32'd1);

    // Simultaneous write and read while full
    in_valid = 1; dac_strobe = 1; rand_data();
    tick();
    chk("sim_level", 32'(level),     32'd2047);
    chk("sim_valid", 32'(out_valid), 32'd1);

    // Enable low for five cycles with active inputs
    for (int n = 0; n < 5; n++) begin
      en = 0; in_valid = 1'($urandom); dac_strobe = 1'($urandom);
      in_done = 1'($urandom); rand_data();
      tick();
    end
    chk("en_level", 32'(level),   32'd2047);
    chk("en_state", 32'(o_state), 32'd2);
    quiet();
    for (int n = 0; n < 100; n++) begin
      dac_strobe = 1;
      tick();
    end
    quiet(); reset = 1;
    tick();
    reset = 0;

    // Drain: 100 samples, done while priming, then 110 strobes
    for (int n = 0; n < 100; n++) begin
      in_valid = 1; rand_data();
      tick();
    end
    quiet(); in_done = 1;
    tick();
    in_done = 0;
    tick(); tick();
    chk("drain_state", 32'(o_state), 32'd3);
    outs = 0; dones = 0;
    for (int n = 0; n < 110; n++) begin
      dac_strobe = 1;
      tick();
      if (out_valid) outs++;
      if (o_done) dones++;
    end
    dac_strobe = 0;
    chk("drain_outs",  32'(outs),          32'd100);
    chk("drain_done",  32'(dones),         32'd1);
    chk("drain_idle",  32'(o_state),       32'd0);
    chk("drain_ufcnt", 32'(underflow_cnt), 32'd0);

    // Random soak
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom % 600) == 0;
      en         = ($urandom % 12) != 0;
      in_valid   = ($urandom % 8) < 4;
      dac_strobe = ($urandom % 8) < 4;
      in_done    = ($urandom % 250) == 0;
      rand_data();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
